// File: rtl/mp_enq_compactor.sv
// Sparse-to-dense enqueue compactor: packs valid input lanes into an ordered holding
// buffer and presents the oldest entries as a prefix-valid bundle to a multi-port FIFO.
module mp_enq_compactor #(
  parameter type payload_t = logic [3:0],
  parameter int  IN_WIDTH  = 4,
  parameter int  OUT_WIDTH = 4,
  parameter int  BUF_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic     [IN_WIDTH-1:0]            in_vld_i,
  input  payload_t [IN_WIDTH-1:0]            in_payload_i,
  output logic     [IN_WIDTH-1:0]            in_rdy_o,
  output logic     [OUT_WIDTH-1:0]           out_vld_o,
  output payload_t [OUT_WIDTH-1:0]           out_payload_o,
  input  logic     [OUT_WIDTH-1:0]           out_rdy_i,
  output logic     [$clog2(BUF_DEPTH+1)-1:0] cnt_o,
  input  logic                               flush_i
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW:0]   DEPTH_X = (CW + 1)'(BUF_DEPTH);
  localparam logic [CW:0]   IN_X    = (CW + 1)'(IN_WIDTH);

  if (BUF_DEPTH < IN_WIDTH || BUF_DEPTH < OUT_WIDTH) begin : g_bad_cfg
    $error("mp_enq_compactor: BUF_DEPTH must be >= IN_WIDTH and >= OUT_WIDTH");
  end

  payload_t [BUF_DEPTH-1:0] slot_q, slot_d, shifted;
  logic     [CW-1:0]        cnt_q, cnt_d;
  logic     [CW-1:0]        k, m, base, off;
  logic     [CW:0]          room;
  logic                     accept;
  logic                     stop;
  logic     [CW-1:0]        lane_pos [IN_WIDTH];

  // Output side is a pure function of registered state: no input-to-output path.
  always_comb begin
    out_vld_o = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      out_vld_o[i] = (cnt_q > CW'(i));
    end
  end

  assign out_payload_o = slot_q[OUT_WIDTH-1:0];
  assign cnt_o         = cnt_q;

  // Only the leading run of fired lanes is consumed; later fires are ignored.
  always_comb begin
    k    = '0;
    stop = 1'b0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (!stop && out_vld_o[i] && out_rdy_i[i]) begin
        k = k + ONE;
      end else begin
        stop = 1'b1;
      end
    end
  end

  // Extra bit keeps the free-space sum from wrapping when the buffer is full.
  always_comb begin
    room   = DEPTH_X - {1'b0, cnt_q} + {1'b0, k};
    accept = (room >= IN_X);
  end

  assign in_rdy_o = {IN_WIDTH{accept}};

  always_comb begin
    m = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (in_vld_i[i]) begin
        m = m + ONE;
      end
    end
  end

  assign base = cnt_q - k;

  // Each valid lane lands at base plus the number of valid lanes below it.
  always_comb begin
    off = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      lane_pos[i] = base + off;
      if (in_vld_i[i]) begin
        off = off + ONE;
      end
    end
  end

  always_comb begin
    shifted = slot_q;
    for (int s = 1; s <= OUT_WIDTH; s++) begin
      if (k == CW'(s)) begin
        for (int j = 0; j < BUF_DEPTH - s; j++) begin
          shifted[j] = slot_q[j+s];
        end
      end
    end
  end

  always_comb begin
    slot_d = shifted;
    if (accept) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        for (int j = 0; j < BUF_DEPTH; j++) begin
          if (in_vld_i[i] && (lane_pos[i] == CW'(j))) begin
            slot_d[j] = in_payload_i[i];
          end
        end
      end
    end
  end

  // Flush wins over both dequeue and enqueue; slot data beyond cnt is don't-care.
  always_comb begin
    cnt_d = base;
    if (accept) begin
      cnt_d = base + m;
    end
    if (flush_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

endmodule

// File: tb/tb_mp_enq_compactor.sv
// Directed vector table plus a queue-model scoreboard for mp_enq_compactor.
module tb_mp_enq_compactor;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [3:0]  in_vld, in_rdy, out_vld, out_rdy, cnt;
  logic [15:0] in_pay, out_pay;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mp_enq_compactor dut (
    .clk          (clk),
    .rst          (rst),
    .in_vld_i     (in_vld),
    .in_payload_i (in_pay),
    .in_rdy_o     (in_rdy),
    .out_vld_o    (out_vld),
    .out_payload_o(out_pay),
    .out_rdy_i    (out_rdy),
    .cnt_o        (cnt),
    .flush_i      (flush)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic [3:0]  vld;
    logic [15:0] pay;
    logic [3:0]  ordy;
    logic        chk_rdy;
    logic [3:0]  e_rdy;
    logic [3:0]  e_cnt;
    logic [3:0]  e_vld;
    logic [15:0] e_pay;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic r, input logic f, input logic [3:0] v,
                              input logic [15:0] p, input logic [3:0] o, input logic cr,
                              input logic [3:0] er, input logic [3:0] ec,
                              input logic [3:0] ev, input logic [15:0] ep);
    vec_t x;
    x.rst = r; x.flush = f; x.vld = v; x.pay = p; x.ordy = o;
    x.chk_rdy = cr; x.e_rdy = er; x.e_cnt = ec; x.e_vld = ev; x.e_pay = ep;
    return x;
  endfunction

  function automatic logic [15:0] lanes(input logic [15:0] p, input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) p[i*4 +: 4] = 4'h0;
    return p;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [3:0]  q[$];
    logic [3:0]  e_rdy, e_vld, r;
    logic [15:0] e_pay;
    logic [4:0]  t5;
    int          kk;
    logic        stop;

    rst = 1'b0; flush = 1'b0; in_vld = '0; in_pay = '0; out_rdy = '0;

    //        rst flush vld      pay       ordy     crdy e_rdy e_cnt e_vld    e_pay
    tv.push_back(mk(1, 0, 4'hF,    16'h1234, 4'h0,    0, 4'h0, 0, 4'h0,    16'h0000));
    tv.push_back(mk(0, 0, 4'b1010, 16'hD0B0, 4'h0,    1, 4'hF, 2, 4'b0011, 16'h00DB));
    tv.push_back(mk(1, 0, 4'h0,    16'h0000, 4'h0,    1, 4'hF, 0, 4'h0,    16'h0000));
    tv.push_back(mk(0, 0, 4'hF,    16'hDCBA, 4'h0,    1, 4'hF, 4, 4'hF,    16'hDCBA));
    tv.push_back(mk(0, 0, 4'b0001, 16'h000E, 4'h0,    1, 4'hF, 5, 4'hF,    16'hDCBA));
    tv.push_back(mk(0, 0, 4'b0001, 16'h000F, 4'b0011, 1, 4'hF, 4, 4'hF,    16'hFEDC));
    tv.push_back(mk(0, 0, 4'h0,    16'h0000, 4'b0001, 1, 4'hF, 3, 4'b0111, 16'h0FED));
    tv.push_back(mk(0, 0, 4'h0,    16'h0000, 4'b0101, 1, 4'hF, 2, 4'b0011, 16'h00FE));
    tv.push_back(mk(0, 0, 4'hF,    16'h4321, 4'h0,    1, 4'hF, 6, 4'hF,    16'h21FE));
    tv.push_back(mk(0, 0, 4'b0011, 16'h0065, 4'h0,    1, 4'h0, 6, 4'hF,    16'h21FE));
    tv.push_back(mk(0, 0, 4'hF,    16'h8765, 4'b0011, 1, 4'hF, 8, 4'hF,    16'h4321));
    tv.push_back(mk(0, 0, 4'hF,    16'h9999, 4'h0,    1, 4'h0, 8, 4'hF,    16'h4321));
    tv.push_back(mk(0, 0, 4'hF,    16'hCBA9, 4'hF,    1, 4'hF, 8, 4'hF,    16'h8765));
    tv.push_back(mk(0, 0, 4'h0,    16'h0000, 4'hF,    1, 4'hF, 4, 4'hF,    16'hCBA9));
    tv.push_back(mk(0, 0, 4'b0101, 16'h0E0D, 4'h0,    1, 4'hF, 6, 4'hF,    16'hCBA9));
    tv.push_back(mk(0, 1, 4'hF,    16'h1111, 4'hF,    1, 4'hF, 0, 4'h0,    16'h0000));
    tv.push_back(mk(0, 0, 4'h0,    16'h0000, 4'hF,    1, 4'hF, 0, 4'h0,    16'h0000));
    tv.push_back(mk(0, 0, 4'hF,    16'h4321, 4'h0,    1, 4'hF, 4, 4'hF,    16'h4321));
    tv.push_back(mk(0, 0, 4'b0111, 16'h0765, 4'h0,    1, 4'hF, 7, 4'hF,    16'h4321));
    tv.push_back(mk(1, 0, 4'hF,    16'hFFFF, 4'h0,    1, 4'h0, 0, 4'h0,    16'h0000));
    tv.push_back(mk(0, 0, 4'h0,    16'h0000, 4'h0,    1, 4'hF, 0, 4'h0,    16'h0000));

    foreach (tv[t]) begin
      @(negedge clk);
      rst = tv[t].rst; flush = tv[t].flush; in_vld = tv[t].vld;
      in_pay = tv[t].pay; out_rdy = tv[t].ordy;
      #1;
      if (tv[t].chk_rdy)
        chk($sformatf("v%0d.in_rdy", t), {12'h0, in_rdy}, {12'h0, tv[t].e_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.cnt", t), {12'h0, cnt}, {12'h0, tv[t].e_cnt});
      chk($sformatf("v%0d.out_vld", t), {12'h0, out_vld}, {12'h0, tv[t].e_vld});
      chk($sformatf("v%0d.payload", t), lanes(out_pay, tv[t].e_vld),
          lanes(tv[t].e_pay, tv[t].e_vld));
    end

    // No combinational bypass: an accepted entry is invisible until the next edge.
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_vld = '0; out_rdy = '0;
    @(negedge clk);
    rst = 1'b0; in_vld = 4'hF; in_pay = 16'h5A5A;
    #1;
    chk("nobypass.out_vld", {12'h0, out_vld}, 16'h0000);
    @(posedge clk);
    #1;
    chk("nobypass.cnt", {12'h0, cnt}, 16'h0004);

    // Random traffic against a queue model.
    @(negedge clk);
    rst = 1'b1; in_vld = '0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      if (c != 0) @(negedge clk);
      flush  = ($urandom_range(0, 39) == 0);
      in_vld = 4'($urandom);
      in_pay = 16'($urandom);
      r      = 4'($urandom);
      t5     = (5'd1 << $urandom_range(0, 4)) - 5'd1;
      out_rdy = (c % 3 == 0) ? r : t5[3:0];
      kk = 0; stop = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!stop && i < q.size() && out_rdy[i]) kk++;
        else stop = 1'b1;
      end
      e_rdy = ((8 - q.size() + kk) >= 4) ? 4'hF : 4'h0;
      #1;
      chk($sformatf("rnd%0d.in_rdy", c), {12'h0, in_rdy}, {12'h0, e_rdy});
      for (int i = 0; i < kk; i++) void'(q.pop_front());
      if (e_rdy[0])
        for (int i = 0; i < 4; i++) if (in_vld[i]) q.push_back(in_pay[i*4 +: 4]);
      if (flush) q.delete();
      @(posedge clk);
      #1;
      e_vld = '0; e_pay = '0;
      for (int i = 0; i < 4; i++) begin
        e_vld[i] = (i < q.size());
        if (i < q.size()) e_pay[i*4 +: 4] = q[i];
      end
      chk($sformatf("rnd%0d.cnt", c), {12'h0, cnt}, 16'(q.size()));
      chk($sformatf("rnd%0d.out_vld", c), {12'h0, out_vld}, {12'h0, e_vld});
      chk($sformatf("rnd%0d.payload", c), lanes(out_pay, e_vld), e_pay);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mp_enq_compactor.md
MP_ENQ_COMPACTOR -- requirements
Module: mp_enq_compactor

Interface
REQ-001 Parameter payload_t, logic[3:0]: lane payload type.
REQ-002 Parameter IN_WIDTH, 4: sparse input lanes.
REQ-003 Parameter OUT_WIDTH, 4: dense output lanes, feeding the multi-port FIFO enqueue side.
REQ-004 Parameter BUF_DEPTH, 8: holding-buffer slots; elaboration SHALL fail unless BUF_DEPTH >= IN_WIDTH and BUF_DEPTH >= OUT_WIDTH.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_vld_i  input  IN_WIDTH  per-lane valid, any bit pattern allowed.
REQ-008 in_payload_i  input  IN_WIDTH x payload_t  lane payloads, lane 0 oldest.
REQ-009 in_rdy_o  output  IN_WIDTH  all-or-none ready, all bits equal.
REQ-010 out_vld_o  output  OUT_WIDTH  dense valid, always a prefix (thermometer).
REQ-011 out_payload_o  output  OUT_WIDTH x payload_t  buffer slots 0..OUT_WIDTH-1.
REQ-012 out_rdy_i  input  OUT_WIDTH  downstream ready, expected prefix-shaped.
REQ-013 cnt_o  output  $clog2(BUF_DEPTH+1)  occupied slot count.
REQ-014 flush_i  input  1  discard all buffered and incoming entries.

Function
REQ-015 Buffer SHALL hold entries dense at slots 0..cnt-1, slot 0 oldest; order SHALL always equal arrival order (earlier cycle first, then lower lane index).
REQ-016 out_vld_o[i] SHALL equal (cnt > i); out_payload_o[i] SHALL equal slot i, driven from registers only.
REQ-017 Dequeue count k SHALL be the number of leading lanes i with out_vld_o[i] & out_rdy_i[i]; fires after the first non-firing lane SHALL be ignored (entry not consumed).
REQ-018 in_rdy_o SHALL be all ones iff (BUF_DEPTH - cnt + k) >= IN_WIDTH; it SHALL NOT depend on in_vld_i.
REQ-019 When in_rdy_o is high, the m = popcount(in_vld_i) valid lanes SHALL be written in ascending lane order to slots cnt-k .. cnt-k+m-1 of the next state; invalid lanes leave no holes.
REQ-020 Same-cycle update: surviving entries SHALL shift down by k, then the compacted input appends; next cnt = cnt - k + m (m = 0 if in_rdy_o low).
REQ-021 Latency: an accepted entry SHALL appear on out_vld_o no earlier than the next cycle; no combinational in->out bypass.
REQ-022 Empty buffer (cnt = 0): all out_vld_o low, k = 0, in_rdy_o high.
REQ-023 Full buffer (cnt = BUF_DEPTH) with k = 0: in_rdy_o low; with k >= IN_WIDTH in the same cycle: in_rdy_o high.
REQ-024 m = 0 with in_rdy_o high SHALL leave the buffer unchanged apart from the dequeue shift.
REQ-025 flush_i high SHALL set next cnt to 0, overriding dequeue and enqueue in that cycle; in_rdy_o still follows REQ-018 and input is dropped.
REQ-026 cnt_o SHALL equal registered cnt; arithmetic at $clog2(BUF_DEPTH+1) bits SHALL never wrap (cnt bounded by REQ-018).
REQ-027 Slot contents at index >= cnt are don't-care and SHALL NOT be visible as valid.

Reset
REQ-028 rst high at a clock edge SHALL set cnt to 0, regardless of flush_i, inputs or current state, including mid-stream.
REQ-029 After reset: out_vld_o = 0, cnt_o = 0, in_rdy_o all ones; payload registers need not be reset.
REQ-030 Inputs presented in the same cycle as rst SHALL be dropped.

Verification
REQ-031 Sparse compaction: cnt=0, in_vld_i=4'b1010 payloads {3:D,1:B}, out_rdy_i=0 -> next cycle out_vld_o=4'b0011, slot0=B, slot1=D, cnt_o=2.
REQ-032 Partial drain with append: cnt=5 (A..E), out_rdy_i=4'b0011, in_vld_i=4'b0001 payload F -> next cnt_o=4, slots C,D,E,F.
REQ-033 Non-prefix ready: cnt=3, out_rdy_i=4'b0101 -> k=1, next cnt_o=2, the lane-2 entry retained.
REQ-034 Full with drain: cnt=8, out_rdy_i=4'b1111, in_vld_i=4'b1111 -> in_rdy_o=4'b1111 same cycle, next cnt_o=8, order preserved; same with out_rdy_i=0 -> in_rdy_o=0, cnt_o stays 8.
REQ-035 Flush: cnt=6, flush_i=1, in_vld_i=4'b1111, out_rdy_i=4'b1111 -> next cnt_o=0, out_vld_o=0, no input retained.
REQ-036 Reset mid-stream: cnt=7, rst=1 with in_vld_i=4'b1111 -> next cnt_o=0, in_rdy_o=4'b1111; random stimulus scoreboard confirms in-order, no-loss, no-duplicate delivery.
